// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption round engine: one round per key_step request,
// with the key schedule supplied externally by key_expansion.

// AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gmul(x, x);
        x4   = gmul(x2, x2);
        x8   = gmul(x4, x4);
        x16  = gmul(x8, x8);
        x32  = gmul(x16, x16);
        x64  = gmul(x32, x32);
        x128 = gmul(x64, x64);
        inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign y = sbox_f(a);
endmodule

// state | meaning
// IDLE  | waiting for a plaintext block, in_ready high
// KREQ  | key_step pulse asking key_expansion for the next round key
// KWAIT | waiting KEY_WAIT-1 further cycles for round_key to settle
// APPLY | one round applied, round_key sampled on this edge
// DONE  | ciphertext presented until out_ready
module aes_round_engine #(
    parameter int NR       = 10,
    parameter int KEY_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         key_step,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);
    typedef enum logic [2:0] {IDLE, KREQ, KWAIT, APPLY, DONE} state_t;

    localparam int            WW        = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = (KEY_WAIT > 1) ? WW'(KEY_WAIT - 2) : '0;
    localparam logic [3:0]    NR_IDX    = 4'(NR);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_cnt;
    logic          key_step_q;
    logic [127:0]  blk, sb, sr, mc, blk_nxt;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        s_box u_s_box (
            .a(blk[127-8*i -: 8]),
            .y(sb[127-8*i -: 8])
        );
    end

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    end

    always_comb begin
        if (round_idx == 4'd0)
            blk_nxt = blk ^ round_key;
        else if (round_idx == NR_IDX)
            blk_nxt = sr ^ round_key;
        else
            blk_nxt = mc ^ round_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_step_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_step_q <= (state_d == KREQ);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = KREQ;
            KREQ:    state_d = (KEY_WAIT > 1) ? KWAIT : APPLY;
            KWAIT:   if (wait_cnt == '0) state_d = APPLY;
            APPLY:   state_d = (round_idx == NR_IDX) ? DONE : KREQ;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        key_step  = key_step_q;
        out_data  = blk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk       <= '0;
            round_idx <= '0;
            wait_cnt  <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                blk       <= in_data;
                round_idx <= '0;
            end else if (state_q == APPLY) begin
                blk <= blk_nxt;
                if (round_idx != NR_IDX) round_idx <= round_idx + 4'd1;
            end
            if (state_q == KREQ)
                wait_cnt <= WAIT_LOAD;
            else if (state_q == KWAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine with a behavioural key_expansion model;
// instance 0 uses KEY_WAIT=1, instance 1 uses KEY_WAIT=3.
module tb_aes_round_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        in_valid, in_ready, key_step, out_valid, out_ready, busy;
    logic [1:0][127:0] in_data, round_key, out_data;
    logic [1:0][3:0]   round_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] rk [11];
    logic         kinit;
    int           kcnt [2];
    int           pulses [2];
    int           last_pulse [2];
    int           bad_gap [2];
    int           cyc = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_engine #(.NR(10), .KEY_WAIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .key_step(key_step[0]), .round_key(round_key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .round_idx(round_idx[0])
    );

    aes_round_engine #(.NR(10), .KEY_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .key_step(key_step[1]), .round_key(round_key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .round_idx(round_idx[1])
    );

    // key_expansion model: each key_step presents the next round key on the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (kinit) begin
                kcnt[d]       <= 0;
                pulses[d]     <= 0;
                last_pulse[d] <= -1;
                bad_gap[d]    <= 0;
                round_key[d]  <= '0;
            end else if (key_step[d]) begin
                round_key[d]  <= (kcnt[d] < 11) ? rk[kcnt[d]] : '0;
                kcnt[d]       <= kcnt[d] + 1;
                pulses[d]     <= pulses[d] + 1;
                last_pulse[d] <= cyc;
                if (last_pulse[d] >= 0 && (cyc - last_pulse[d]) != ((d == 0) ? 2 : 4))
                    bad_gap[d] <= bad_gap[d] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv, s, c;
        inv = '0;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = tb_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic init_keys(input logic [127:0] key);
        expand_key(key);
        kinit = 1'b1;
        @(posedge clk); #1;
        kinit = 1'b0;
    endtask

    task automatic accept(input int d, input logic [127:0] pt, input bit hold);
        int n;
        n = 0;
        while (!in_ready[d] && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("in_ready_before_accept", 128'(in_ready[d]), 128'd1);
        in_data[d]  = pt;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid[d] = 1'b0;
        check_eq("busy_after_accept", 128'(busy[d]), 128'd1);
    endtask

    task automatic run_block(input int d, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int lat_exp, input int bp, input bit hold);
        int lat;
        int bad_ready;
        init_keys(key);
        accept(d, pt, hold);
        lat = 0;
        bad_ready = 0;
        while (!out_valid[d] && lat < 200) begin
            if (hold) begin
                in_data[d] = {$urandom, $urandom, $urandom, $urandom};
                if (in_ready[d]) bad_ready++;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid[d] = 1'b0;
        check_eq("latency", 128'(lat), 128'(lat_exp));
        check_eq("ciphertext", out_data[d], ct);
        check_eq("key_step_count", 128'(pulses[d]), 128'd11);
        check_eq("key_step_spacing", 128'(bad_gap[d]), 128'd0);
        check_eq("round_idx_final", 128'(round_idx[d]), 128'd10);
        if (hold) check_eq("in_ready_while_busy", 128'(bad_ready), 128'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check_eq("bp_out_data", out_data[d], ct);
            check_eq("bp_out_valid", 128'(out_valid[d]), 128'd1);
            check_eq("bp_in_ready", 128'(in_ready[d]), 128'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check_eq("out_valid_after_hs", 128'(out_valid[d]), 128'd0);
        check_eq("in_ready_after_hs", 128'(in_ready[d]), 128'd1);
        check_eq("busy_after_hs", 128'(busy[d]), 128'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        kinit     = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready[0]), 128'd1);
        check_eq("rst_key_step", 128'(key_step[0]), 128'd0);
        check_eq("rst_out_valid", 128'(out_valid[0]), 128'd0);
        check_eq("rst_out_data", out_data[0], 128'd0);
        check_eq("rst_busy", 128'(busy[0]), 128'd0);
        check_eq("rst_round_idx", 128'(round_idx[0]), 128'd0);
        rst_n = 1'b1;
        kinit = 1'b0;
        @(posedge clk); #1;

        run_block(0, KEY_C, PT_C, CT_C, 22, 0, 1'b0);
        run_block(0, KEY_B, PT_B, CT_B, 22, 10, 1'b0);
        run_block(0, KEY_C, PT_C, CT_C, 22, 0, 1'b1);

        // Abort in round 5 while key_step is high, then check the outputs drop before any edge.
        init_keys(KEY_B);
        accept(0, PT_B, 1'b0);
        n = 0;
        while (!(round_idx[0] == 4'd5 && key_step[0]) && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("round5_key_step", 128'(key_step[0]), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 128'(busy[0]), 128'd0);
        check_eq("abort_key_step", 128'(key_step[0]), 128'd0);
        check_eq("abort_out_valid", 128'(out_valid[0]), 128'd0);
        check_eq("abort_in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, KEY_B, PT_B, CT_B, 22, 0, 1'b0);

        run_block(1, KEY_B, PT_B, CT_B, 44, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
